add3_csa_pipe: RTL and testbench
================================

// Module: add3_csa_pipe
// PURPOSE
//   Parametrised, pipelined three-operand adder. It is the sequential successor of the
//   combinational 3-input adder netlists.
//   - Stage 1 is a carry-save (3:2) compressor; stage 2 is a carry-propagate adder.
//   - Stage 2 can optionally fold in a running accumulator.
//   - Valid/ready handshake on both sides. Sits between operand sources and the datapath sink.
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>=2)
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous reset, active-high
//   in1        in   WIDTH    operand A
//   in2        in   WIDTH    operand B
//   in3        in   WIDTH    operand C
//   in_acc     in   1        1: add the accumulator into this transaction's result
//   in_valid   in   1        operands/in_acc valid
//   in_ready   out  1        block can accept this cycle
//   out1       out  WIDTH    result modulo 2^WIDTH
//   out_cout   out  2        bits [WIDTH+1:WIDTH] of the full sum
//   out_valid  out  1        out1/out_cout valid
//   out_ready  in   1        sink accepts this cycle
//   acc_q      out  WIDTH    current accumulator value
// BEHAVIOUR
//   Reset (async, rst=1)
//   - All valid flags clear; out1, out_cout, acc_q and all pipeline registers go to 0.
//   - Any in-flight data is discarded; no partial result is ever presented.
//   Handshake
//   - A transfer happens on a rising edge with valid&&ready.
//   - While out_valid=1 and out_ready=0, out1/out_cout are held stable.
//   - A producer must hold its data stable until the transfer.
//   Stage 1 (register v1, s1, c1, a1)
//   - s1 = in1^in2^in3; c1 = maj(in1,in2,in3); a1 = in_acc.
//   - Loads when in_valid && in_ready.
//   Stage 2 (register out_valid, out1, out_cout)
//   - Loads when v1 && (!out_valid || out_ready).
//   - Computes full = s1 + (c1<<1) + (a1 ? acc_q : 0) at WIDTH+2 bits.
//   - out1 = full[WIDTH-1:0]; out_cout = full[WIDTH+1:WIDTH].
//   - 4*(2^WIDTH-1) < 2^(WIDTH+2), so the full sum never overflows.
//   Accumulator
//   - acc_q <= full[WIDTH-1:0] on every stage-2 load, whatever in_acc was.
//   - A back-to-back in_acc=1 transaction therefore sees the immediately preceding result;
//     no bubble is required.
//   Valid and ready logic
//   - v1 next state: set on a stage-1 load; cleared when stage 2 loads without a new stage-1 load.
//   - out_valid next state: set on a stage-2 load; cleared when out_ready && !v1.
//   - in_ready = !v1 || !out_valid || out_ready. This is a combinational path from out_ready.
//   Latency and throughput
//   - Latency is 2 cycles, input transfer to out_valid, with out_ready held high.
//   - Throughput is 1 transaction per cycle.
//   Capacity and ordering
//   - When full: 2 transactions held (v1 && out_valid) with out_ready=0, which forces in_ready=0.
//   - A simultaneous stage-2 drain and stage-1 refill in the same cycle must lose no data.
//   - Results leave in strict input order; none are dropped or duplicated.
// TESTING (WIDTH=4 unless noted)
//   1. Basic sum, out_ready=1: 7,5,3, in_acc=0 -> 2 cycles later out1=15, out_cout=0, acc_q=15.
//   2. Maximum sum: 15,15,15 -> out1=13, out_cout=2 (45=0b101101).
//   3. Accumulate, back-to-back:
//      - 1,2,3 acc=0, then 1,1,1 acc=1 -> out1=6, then out1=9, acc_q=9.
//      - Then 15,15,15 acc=1 -> full=54 -> out1=6, out_cout=3.
//   4. Backpressure:
//      - Hold out_ready=0 and send 4 transactions -> in_ready drops after 2 are held,
//        out1 stays stable.
//      - Release -> results appear in order, one per cycle.
//   5. Reset mid-operation: assert rst async while both stages are valid
//      -> out_valid=0, out1=0, acc_q=0 immediately; nothing emitted after release.
//   6. Random soak, WIDTH=8 and WIDTH=16:
//      - Random valid/ready, compared against a reference model, 10k transactions.
//      - No loss or reorder; out1/out_cout/acc match.

Source files
------------

// File: rtl/add3_csa_pipe.sv
// add3_csa_pipe: two-stage pipelined three-operand adder.
// Stage 1 is a carry-save (3:2) compressor. Stage 2 is a carry-propagate adder
// that can also fold in a running accumulator. Both sides use valid/ready.
module add3_csa_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             in_acc,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [1:0]       out_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_q
);

  // Bitwise sum output of a 3:2 compressor.
  function automatic logic [WIDTH-1:0] csa_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
    csa_sum = a ^ b ^ c;
  endfunction

  // Bitwise majority (carry) output of a 3:2 compressor.
  function automatic logic [WIDTH-1:0] csa_carry(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
    csa_carry = (a & b) | (a & c) | (b & c);
  endfunction

  // Stage-1 registers.
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] c1_q, c1_d;
  logic             a1_q, a1_d;

  // Stage-2 registers.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [1:0]       out_cout_q, out_cout_d;
  logic [WIDTH-1:0] acc_d;

  // Handshake and datapath intermediates.
  logic             s1_load;
  logic             s2_load;
  logic [WIDTH+1:0] full_sum;

  // Handshake decisions; in_ready depends combinationally on out_ready so a
  // full pipeline can drain and refill in the same cycle.
  always_comb begin
    in_ready = !v1_q || !out_valid_q || out_ready;
    s1_load  = in_valid && in_ready;
    s2_load  = v1_q && (!out_valid_q || out_ready);
  end

  // Carry-propagate add of the compressed pair plus the optional accumulator.
  // WIDTH+2 bits hold the worst case 4*(2^WIDTH-1) without overflow.
  always_comb begin
    full_sum = {2'b00, s1_q} + {1'b0, c1_q, 1'b0};
    if (a1_q) begin
      full_sum = full_sum + {2'b00, acc_q};
    end else begin
      full_sum = full_sum + {(WIDTH+2){1'b0}};
    end
  end

  // Next-state for stage 1: capture the compressed operands on each accepted input.
  always_comb begin
    v1_d = v1_q;
    s1_d = s1_q;
    c1_d = c1_q;
    a1_d = a1_q;
    if (s1_load) begin
      v1_d = 1'b1;
      s1_d = csa_sum(in1, in2, in3);
      c1_d = csa_carry(in1, in2, in3);
      a1_d = in_acc;
    end else if (s2_load) begin
      v1_d = 1'b0;
    end else begin
      v1_d = v1_q;
    end
  end

  // Next-state for stage 2 and the accumulator; the accumulator tracks every
  // result so a back-to-back accumulate sees the immediately preceding sum.
  always_comb begin
    out_valid_d = out_valid_q;
    out1_d      = out1_q;
    out_cout_d  = out_cout_q;
    acc_d       = acc_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out1_d      = full_sum[WIDTH-1:0];
      out_cout_d  = full_sum[WIDTH+1:WIDTH];
      acc_d       = full_sum[WIDTH-1:0];
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline state registers; reset discards all in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      s1_q        <= {WIDTH{1'b0}};
      c1_q        <= {WIDTH{1'b0}};
      a1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out1_q      <= {WIDTH{1'b0}};
      out_cout_q  <= 2'b00;
      acc_q       <= {WIDTH{1'b0}};
    end else begin
      v1_q        <= v1_d;
      s1_q        <= s1_d;
      c1_q        <= c1_d;
      a1_q        <= a1_d;
      out_valid_q <= out_valid_d;
      out1_q      <= out1_d;
      out_cout_q  <= out_cout_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out1      = out1_q;
  assign out_cout  = out_cout_q;

endmodule

// File: tb/tb_add3_csa_pipe.sv
// tb_add3_csa_pipe: directed table and handshake sequences on a WIDTH=4 instance,
// plus a random valid/ready soak on WIDTH=8 and WIDTH=16 instances against a
// transaction-level reference model.
module tb_add3_csa_pipe;

  logic clk;
  logic rst;

  // WIDTH=4 instance signals
  logic [3:0] a4, b4, c4, o4, accq4;
  logic       acc4, iv4, ir4, ov4, or4;
  logic [1:0] co4;

  // Soak instances (WIDTH=8 takes the low byte of the shared operands)
  logic [15:0] sa, sb, sc;
  logic        sacc, siv, sor;
  logic        ir8, ir16, ov8, ov16;
  logic [7:0]  o8, accq8;
  logic [15:0] o16, accq16;
  logic [1:0]  co8, co16;

  int checks   = 0;
  int failures = 0;

  add3_csa_pipe #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in1(a4), .in2(b4), .in3(c4), .in_acc(acc4),
    .in_valid(iv4), .in_ready(ir4), .out1(o4), .out_cout(co4),
    .out_valid(ov4), .out_ready(or4), .acc_q(accq4));

  add3_csa_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in1(sa[7:0]), .in2(sb[7:0]), .in3(sc[7:0]), .in_acc(sacc),
    .in_valid(siv), .in_ready(ir8), .out1(o8), .out_cout(co8),
    .out_valid(ov8), .out_ready(sor), .acc_q(accq8));

  add3_csa_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in1(sa), .in2(sb), .in3(sc), .in_acc(sacc),
    .in_valid(siv), .in_ready(ir16), .out1(o16), .out_cout(co16),
    .out_valid(ov16), .out_ready(sor), .acc_q(accq16));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] a, b, c;
    logic       acc;
    logic [3:0] o;
    logic [1:0] co;
    logic [3:0] accv;
  } vec_t;

  vec_t tbl[8];

  // Soak reference model: full sums in input order, plus model accumulators
  int q8[$], q16[$];
  int m8, m16;
  logic       hold16, hold8;
  logic [15:0] prev16;
  logic [7:0]  prev8;

  task automatic soak_observe();
    int e;
    if (hold16) chk("soak_hold16", int'(o16), int'(prev16));
    if (hold8)  chk("soak_hold8", int'(o8), int'(prev8));
    if (ov16 && sor) begin
      if (q16.size() == 0) chk("soak_spurious16", 1, 0);
      else begin
        e = q16.pop_front();
        chk("soak_out16", int'(o16), e & 32'hFFFF);
        chk("soak_cout16", int'(co16), e >> 16);
      end
    end
    if (ov8 && sor) begin
      if (q8.size() == 0) chk("soak_spurious8", 1, 0);
      else begin
        e = q8.pop_front();
        chk("soak_out8", int'(o8), e & 32'hFF);
        chk("soak_cout8", int'(co8), e >> 8);
      end
    end
    if (siv) chk("soak_ready_eq", int'(ir8), int'(ir16));
    if (siv && ir16) begin
      e = int'(sa) + int'(sb) + int'(sc) + (sacc ? m16 : 0);
      m16 = e & 32'hFFFF;
      q16.push_back(e);
      e = int'(sa[7:0]) + int'(sb[7:0]) + int'(sc[7:0]) + (sacc ? m8 : 0);
      m8 = e & 32'hFF;
      q8.push_back(e);
    end
    hold16 = ov16 && !sor;
    hold8  = ov8 && !sor;
    prev16 = o16;
    prev8  = o8;
  endtask

  initial begin
    int i, k, first_out, n, got, bp_first, bp_last, n_in, cyc;
    logic fire;

    tbl[0] = '{4'd7,  4'd5,  4'd3,  1'b0, 4'd15, 2'd0, 4'd15};
    tbl[1] = '{4'd15, 4'd15, 4'd15, 1'b0, 4'd13, 2'd2, 4'd13};
    tbl[2] = '{4'd1,  4'd2,  4'd3,  1'b0, 4'd6,  2'd0, 4'd6};
    tbl[3] = '{4'd1,  4'd1,  4'd1,  1'b1, 4'd9,  2'd0, 4'd9};
    tbl[4] = '{4'd15, 4'd15, 4'd15, 1'b1, 4'd6,  2'd3, 4'd6};
    tbl[5] = '{4'd0,  4'd0,  4'd0,  1'b1, 4'd6,  2'd0, 4'd6};
    tbl[6] = '{4'd8,  4'd8,  4'd8,  1'b0, 4'd8,  2'd1, 4'd8};
    tbl[7] = '{4'd0,  4'd0,  4'd0,  1'b0, 4'd0,  2'd0, 4'd0};

    clk = 1'b0; rst = 1'b1;
    a4 = 4'd0; b4 = 4'd0; c4 = 4'd0; acc4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
    sa = 16'd0; sb = 16'd0; sc = 16'd0; sacc = 1'b0; siv = 1'b0; sor = 1'b0;
    m8 = 0; m16 = 0; hold8 = 1'b0; hold16 = 1'b0; prev8 = 8'd0; prev16 = 16'd0;

    // Reset state
    #12;
    chk("rst_out_valid", int'(ov4), 0);
    chk("rst_out1", int'(o4), 0);
    chk("rst_cout", int'(co4), 0);
    chk("rst_acc", int'(accq4), 0);
    chk("rst_in_ready", int'(ir4), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: back-to-back transactions with the sink always ready
    or4 = 1'b1; i = 0; k = 0; first_out = -1;
    for (int cy = 0; cy < 12; cy++) begin
      if (i < 8) begin
        a4 = tbl[i].a; b4 = tbl[i].b; c4 = tbl[i].c; acc4 = tbl[i].acc; iv4 = 1'b1;
      end else begin
        iv4 = 1'b0;
      end
      @(negedge clk);
      if (ov4 && k < 8) begin
        if (first_out < 0) first_out = cy;
        chk($sformatf("tbl%0d_out1", k), int'(o4), int'(tbl[k].o));
        chk($sformatf("tbl%0d_cout", k), int'(co4), int'(tbl[k].co));
        chk($sformatf("tbl%0d_acc", k), int'(accq4), int'(tbl[k].accv));
        k++;
      end
      if (iv4 && ir4) i++;
      @(posedge clk); #1;
    end
    chk("tbl_count", k, 8);
    chk("tbl_latency", first_out, 2);

    // Backpressure: sink stalled, four offered, only two fit
    or4 = 1'b0; n = 0; b4 = 4'd0; c4 = 4'd0; acc4 = 1'b0;
    for (int cy = 0; cy < 6; cy++) begin
      if (n < 4) begin a4 = 4'(n + 1); iv4 = 1'b1; end else iv4 = 1'b0;
      @(negedge clk);
      if (iv4 && ir4) n++;
      if (ov4) chk("bp_hold", int'(o4), 1);
      @(posedge clk); #1;
    end
    chk("bp_accepted", n, 2);
    chk("bp_in_ready", int'(ir4), 0);

    // Release: results drain in order, one per cycle, while the rest are refilled
    or4 = 1'b1; got = 0; bp_first = -1; bp_last = -1;
    for (int cy = 0; cy < 12; cy++) begin
      if (n < 4) begin a4 = 4'(n + 1); iv4 = 1'b1; end else iv4 = 1'b0;
      @(negedge clk);
      if (ov4 && or4) begin
        chk("bp_order", int'(o4), got + 1);
        if (bp_first < 0) bp_first = cy;
        bp_last = cy;
        got++;
      end
      if (iv4 && ir4) n++;
      @(posedge clk); #1;
    end
    chk("bp_results", got, 4);
    chk("bp_back_to_back", bp_last - bp_first, 3);

    // Reset in the middle with both stages holding data
    or4 = 1'b0; n = 0; a4 = 4'd5; b4 = 4'd6; c4 = 4'd7; acc4 = 1'b1;
    for (int cy = 0; cy < 3; cy++) begin
      iv4 = (n < 2);
      @(negedge clk);
      if (iv4 && ir4) n++;
      @(posedge clk); #1;
    end
    iv4 = 1'b0;
    chk("full_out_valid", int'(ov4), 1);
    chk("full_in_ready", int'(ir4), 0);
    chk("full_acc_nonzero", int'(accq4 != 4'd0), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(ov4), 0);
    chk("arst_out1", int'(o4), 0);
    chk("arst_cout", int'(co4), 0);
    chk("arst_acc", int'(accq4), 0);
    @(negedge clk);
    rst = 1'b0; or4 = 1'b1;
    for (int cy = 0; cy < 4; cy++) begin
      @(negedge clk);
      chk("arst_no_emit", int'(ov4), 0);
    end
    @(posedge clk); #1;

    // Random soak on WIDTH=8 and WIDTH=16
    m8 = 0; m16 = 0; n_in = 0; cyc = 0;
    sa = 16'($urandom); sb = 16'($urandom); sc = 16'($urandom);
    sacc = 1'($urandom); siv = 1'b1; sor = 1'b1;
    while (n_in < 10000 && cyc < 40000) begin
      @(negedge clk);
      fire = siv && ir16;
      if (fire) n_in++;
      soak_observe();
      @(posedge clk); #1;
      if (fire || !siv) begin
        sa = 16'($urandom); sb = 16'($urandom); sc = 16'($urandom);
        sacc = 1'($urandom);
        siv = ($urandom_range(0, 3) != 0) && (n_in < 10000);
      end
      sor = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("soak_progress", n_in, 10000);
    siv = 1'b0; sor = 1'b1;
    for (int cy = 0; cy < 10; cy++) begin
      @(negedge clk);
      soak_observe();
      @(posedge clk); #1;
    end
    chk("soak_drain16", q16.size(), 0);
    chk("soak_drain8", q8.size(), 0);
    chk("soak_acc16", int'(accq16), m16);
    chk("soak_acc8", int'(accq8), m8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
